pipe_hazard_ctrl: RTL and testbench

// Parametrised hazard/forwarding/halt controller for the in-order RISC-V pipeline. Keeps a

---
 rtl/pipe_hazard_if.sv | 48 ++++
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// Pipeline-side signal bundle for pipe_hazard_ctrl: ID/EX inputs, forwarded operands, stall/halt.
// HAZARD_STATS_EN adds the stall_cnt/fwd_cnt observation outputs.
interface pipe_hazard_if #(
    parameter int XLEN      = 64,
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2
);
    localparam int SELW = $clog2(FWD_DEPTH + 1);

    logic                        id_valid;
    logic                        id_wr;
    logic                        id_is_load;
    logic                        id_is_halt;
    logic [REG_AW-1:0]           id_rd;
    logic [NUM_SRC*REG_AW-1:0]   id_rs;
    logic [NUM_SRC-1:0]          id_rs_used;
    logic                        flush;
    logic [NUM_SRC*XLEN-1:0]     ex_rf_data;
    logic [FWD_DEPTH*XLEN-1:0]   stage_data;
    logic [NUM_SRC*XLEN-1:0]     ex_opnd;
    logic [NUM_SRC*SELW-1:0]     fwd_sel;
    logic                        stall;
    logic                        if_hold;
    logic                        halt;
`ifdef HAZARD_STATS_EN
    logic [31:0]                 stall_cnt;
    logic [31:0]                 fwd_cnt;
`endif

    modport master (
        output id_valid, id_wr, id_is_load, id_is_halt, id_rd, id_rs, id_rs_used,
        output flush, ex_rf_data, stage_data,
        input  ex_opnd, fwd_sel, stall, if_hold, halt
`ifdef HAZARD_STATS_EN
        , input stall_cnt, fwd_cnt
`endif
    );

    modport slave (
        input  id_valid, id_wr, id_is_load, id_is_halt, id_rd, id_rs, id_rs_used,
        input  flush, ex_rf_data, stage_data,
        output ex_opnd, fwd_sel, stall, if_hold, halt
`ifdef HAZARD_STATS_EN
        , output stall_cnt, fwd_cnt
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding/halt controller: shadow tag pipe EX..WB, EX forwarding select, ID load-use stall,
// halt-drain FSM. Optional HAZARD_STATS_EN adds saturating stall/forward counters.
module pipe_hazard_ctrl #(
    parameter int XLEN       = 64,
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2
) (
    input  logic        clk,
    input  logic        rst,
    pipe_hazard_if.slave bus
);
    localparam int SELW = $clog2(FWD_DEPTH + 1);
    localparam int CNTW = $clog2(FWD_DEPTH + 2);

    typedef struct packed {
        logic                             valid;
        logic                             wr;
        logic                             is_load;
        logic [REG_AW-1:0]                rd;
        logic [NUM_SRC-1:0][REG_AW-1:0]   rs;
        logic [NUM_SRC-1:0]               used;
    } tag_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t                            r_state, w_state_n;
    logic [CNTW-1:0]                   r_cnt, w_cnt_n;
    tag_t                              r_tag [0:FWD_DEPTH];
    tag_t                              w_id_tag;
    logic [NUM_SRC-1:0][SELW-1:0]      w_sel;
    logic [NUM_SRC-1:0][XLEN-1:0]      w_opnd;
    logic [NUM_SRC-1:0][XLEN-1:0]      w_rf;
    logic [FWD_DEPTH-1:0][XLEN-1:0]    w_stage;
    logic [NUM_SRC-1:0]                w_blk, w_haz;
    logic                              w_stall, w_accept, w_ex_hazard;

    function automatic logic f_match(tag_t t, logic [REG_AW-1:0] r);
        return t.valid & t.wr & (t.rd == r) & (r != '0);
    endfunction

    function automatic logic f_ready(tag_t t, int k);
        return ~t.is_load | (k >= LOAD_STAGE);
    endfunction

    assign w_rf    = bus.ex_rf_data;
    assign w_stage = bus.stage_data;

    always_comb begin
        w_id_tag         = '0;
        w_id_tag.valid   = 1'b1;
        w_id_tag.wr      = bus.id_wr;
        w_id_tag.is_load = bus.id_is_load;
        w_id_tag.rd      = bus.id_rd;
        w_id_tag.rs      = bus.id_rs;
        w_id_tag.used    = bus.id_rs_used;
    end

    // Descending scans: the last hit is the youngest producer, so an older match never wins.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_sel[i]  = '0;
            w_opnd[i] = w_rf[i];
            w_haz[i]  = 1'b0;
            w_blk[i]  = 1'b0;
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (r_tag[0].valid && r_tag[0].used[i] && f_match(r_tag[k], r_tag[0].rs[i])) begin
                    w_sel[i] = SELW'(k);
                    w_haz[i] = ~f_ready(r_tag[k], k);
                end
            end
            for (int k = 1; k <= FWD_DEPTH; k++)
                if (w_sel[i] == SELW'(k)) w_opnd[i] = w_stage[k-1];
            // Producer at j now sits at j+1 when the ID instruction reaches EX.
            for (int j = FWD_DEPTH - 1; j >= 0; j--)
                if (bus.id_rs_used[i] && f_match(r_tag[j], w_id_tag.rs[i]))
                    w_blk[i] = ~f_ready(r_tag[j], j + 1);
        end
    end

    assign w_ex_hazard = |w_haz;
    assign w_stall     = (|w_blk) & bus.id_valid & ~bus.flush & (r_state == RUN);
    assign w_accept    = bus.id_valid & ~w_stall & ~bus.flush & (r_state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= FWD_DEPTH; k++) r_tag[k] <= '0;
        end else begin
            r_tag[0] <= w_accept ? w_id_tag : '0;
            for (int k = 1; k <= FWD_DEPTH; k++) r_tag[k] <= r_tag[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // Count reaching 0 coincides with entering HALTED: halt rises FWD_DEPTH+2 cycles after acceptance.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        case (r_state)
            RUN: begin
                if (w_accept && bus.id_is_halt) begin
                    w_state_n = DRAIN;
                    w_cnt_n   = CNTW'(FWD_DEPTH + 1);
                end
            end
            DRAIN: begin
                w_cnt_n = (r_cnt == '0) ? '0 : r_cnt - CNTW'(1);
                if (r_cnt <= CNTW'(1)) w_state_n = HALTED;
            end
            HALTED: ;
            default: w_state_n = RUN;
        endcase
    end

    assign bus.fwd_sel = w_sel;
    assign bus.ex_opnd = w_opnd;
    assign bus.stall   = w_stall;
    assign bus.if_hold = (r_state != RUN);
    assign bus.halt    = (r_state == HALTED);

    a_no_unready_fwd: assert property (@(posedge clk) disable iff (rst) !w_ex_hazard);

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt, r_fwd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
            if ((|w_sel) && (r_fwd_cnt != '1))  r_fwd_cnt   <= r_fwd_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.fwd_cnt   = r_fwd_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against an instruction-age model of the pipeline.
module tb_pipe_hazard_ctrl;
    localparam int XL   = 64;
    localparam int AW   = 5;
    localparam int NS   = 2;
    localparam int D    = 2;
    localparam int LS   = 2;
    localparam int SELW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_if #(.XLEN(XL), .REG_AW(AW), .NUM_SRC(NS), .FWD_DEPTH(D)) bus();
    pipe_hazard_ctrl #(.XLEN(XL), .REG_AW(AW), .NUM_SRC(NS), .FWD_DEPTH(D), .LOAD_STAGE(LS))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int vec  = 0;
    int miss = 0;

    // Model: what entered EX 'age' cycles ago; age k == stage k.
    bit h_v  [0:D];
    bit h_wr [0:D];
    bit h_ld [0:D];
    int h_rd [0:D];
    int h_rs [0:D][NS];
    bit h_u  [0:D][NS];
    int cyc    = 0;
    int t_halt = -1;
    bit e_accept;
`ifdef HAZARD_STATS_EN
    int m_stalls = 0;
    int m_fwds   = 0;
`endif

    localparam logic [63:0] DA = 64'hAAAA_0000_AAAA_1111;
    localparam logic [63:0] DB = 64'hBBBB_2222_BBBB_3333;
    localparam logic [63:0] R0 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] R1 = 64'h2222_2222_2222_2222;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit prod(int k, int r);
        return h_v[k] && h_wr[k] && (h_rd[k] == r) && (r != 0);
    endfunction

    task automatic model_clear();
        for (int k = 0; k <= D; k++) begin
            h_v[k] = 0; h_wr[k] = 0; h_ld[k] = 0; h_rd[k] = 0;
            for (int i = 0; i < NS; i++) begin h_rs[k][i] = 0; h_u[k][i] = 0; end
        end
        t_halt = -1;
`ifdef HAZARD_STATS_EN
        m_stalls = 0;
        m_fwds   = 0;
`endif
    endtask

    task automatic set_id(input bit v, input bit wr, input bit ld, input bit hlt,
                          input int rd, input int rs0, input int rs1, input logic [1:0] used);
        bus.id_valid   = v;
        bus.id_wr      = wr;
        bus.id_is_load = ld;
        bus.id_is_halt = hlt;
        bus.id_rd      = AW'(rd);
        bus.id_rs      = {AW'(rs1), AW'(rs0)};
        bus.id_rs_used = used;
        bus.flush      = 1'b0;
    endtask

    // Negedge half: derive expectations from the model and compare every output.
    task automatic half_a();
        logic [NS*SELW-1:0] esel;
        logic [NS*XL-1:0]   eop;
        bit raw, run, est;
        int s;
        @(negedge clk);
        esel = '0;
        eop  = bus.ex_rf_data;
        for (int i = 0; i < NS; i++) begin
            s = 0;
            if (h_v[0] && h_u[0][i])
                for (int k = 1; k <= D; k++) if (s == 0 && prod(k, h_rs[0][i])) s = k;
            esel[i*SELW +: SELW] = SELW'(s);
            if (s != 0) eop[i*XL +: XL] = bus.stage_data[(s-1)*XL +: XL];
        end
        raw = 0;
        for (int i = 0; i < NS; i++) begin
            if (bus.id_rs_used[i]) begin
                s = -1;
                for (int j = 0; j < D; j++)
                    if (s < 0 && prod(j, int'(bus.id_rs[i*AW +: AW]))) s = j;
                if (s >= 0 && h_ld[s] && (s + 1 < LS)) raw = 1;
            end
        end
        run      = (t_halt < 0);
        est      = raw && bus.id_valid && !bus.flush && run;
        e_accept = bus.id_valid && !est && !bus.flush && run;
        chk("fwd_sel", 128'(bus.fwd_sel), 128'(esel));
        chk("ex_opnd", 128'(bus.ex_opnd), 128'(eop));
        chk("stall",   128'(bus.stall),   128'(est));
        chk("if_hold", 128'(bus.if_hold), 128'(t_halt >= 0));
        chk("halt",    128'(bus.halt),    128'(t_halt >= 0 && cyc >= t_halt + D + 2));
`ifdef HAZARD_STATS_EN
        if (est) m_stalls++;
        if (esel != '0) m_fwds++;
`endif
    endtask

    // Posedge half: age every in-flight instruction by one stage.
    task automatic half_b();
        @(posedge clk);
        for (int k = D; k >= 1; k--) begin
            h_v[k] = h_v[k-1]; h_wr[k] = h_wr[k-1]; h_ld[k] = h_ld[k-1]; h_rd[k] = h_rd[k-1];
            for (int i = 0; i < NS; i++) begin h_rs[k][i] = h_rs[k-1][i]; h_u[k][i] = h_u[k-1][i]; end
        end
        h_v[0]  = e_accept;
        h_wr[0] = e_accept && bus.id_wr;
        h_ld[0] = e_accept && bus.id_is_load;
        h_rd[0] = int'(bus.id_rd);
        for (int i = 0; i < NS; i++) begin
            h_rs[0][i] = int'(bus.id_rs[i*AW +: AW]);
            h_u[0][i]  = e_accept && bus.id_rs_used[i];
        end
        if (e_accept && bus.id_is_halt) t_halt = cyc;
        cyc++;
        #1;
    endtask

    task automatic cycle();
        half_a();
        half_b();
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        half_a();
        chk("rst_fwd_sel", 128'(bus.fwd_sel), 128'(0));
        chk("rst_ex_opnd", 128'(bus.ex_opnd), 128'(bus.ex_rf_data));
        chk("rst_ctl", 128'({bus.stall, bus.if_hold, bus.halt}), 128'(3'b000));
`ifdef HAZARD_STATS_EN
        chk("rst_stall_cnt", 128'(bus.stall_cnt), 128'(0));
`endif
        #1 rst = 1'b0;
        half_b();
    endtask

    task automatic randomize_inputs();
        set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               $urandom_range(0, 149) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 2'($urandom_range(0, 3)));
        bus.flush      = (t_halt < 0) && ($urandom_range(0, 9) == 0);
        bus.ex_rf_data = {$urandom, $urandom, $urandom, $urandom};
        bus.stage_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        bus.ex_rf_data = {R1, R0};
        bus.stage_data = {DB, DA};
        model_clear();
        do_reset();

        // add x5; add x6,x5,x5 -> both sources from stage 1
        set_id(1, 1, 0, 0, 5, 0, 0, 2'b00); cycle();
        set_id(1, 1, 0, 0, 6, 5, 5, 2'b11); half_a();
        chk("t1_stall", 128'(bus.stall), 128'(0)); half_b();
        set_id(0, 0, 0, 0, 0, 0, 0, 2'b00); half_a();
        chk("t1_fwd_sel", 128'(bus.fwd_sel), 128'(4'b0101));
        chk("t1_ex_opnd", 128'(bus.ex_opnd), {DA, DA}); half_b();
        idle(3);

        // ld x6; use x6 -> one bubble, then forwarded from stage 2
        set_id(1, 1, 1, 0, 6, 0, 0, 2'b00); cycle();
        set_id(1, 1, 0, 0, 7, 6, 0, 2'b01); half_a();
        chk("t2_stall_on", 128'(bus.stall), 128'(1)); half_b();
        half_a();
        chk("t2_stall_off", 128'(bus.stall), 128'(0)); half_b();
        set_id(0, 0, 0, 0, 0, 0, 0, 2'b00); half_a();
        chk("t2_fwd_sel", 128'(bus.fwd_sel), 128'(4'b0010));
        chk("t2_ex_opnd", 128'(bus.ex_opnd), {R1, DB}); half_b();
        idle(3);

        // x0 is never forwarded and never stalls
        set_id(1, 1, 0, 0, 0, 0, 0, 2'b00); cycle();
        set_id(1, 0, 0, 0, 0, 0, 0, 2'b11); cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 2'b00); half_a();
        chk("t3_fwd_sel", 128'(bus.fwd_sel), 128'(0));
        chk("t3_ex_opnd", 128'(bus.ex_opnd), {R1, R0}); half_b();
        set_id(1, 1, 1, 0, 0, 0, 0, 2'b00); cycle();
        set_id(1, 0, 0, 0, 0, 0, 0, 2'b01); half_a();
        chk("t3_ld_x0_stall", 128'(bus.stall), 128'(0)); half_b();
        idle(3);

        // x7 in stages 1 and 2 -> youngest wins
        set_id(1, 1, 0, 0, 7, 0, 0, 2'b00); cycle();
        set_id(1, 1, 0, 0, 7, 0, 0, 2'b00); cycle();
        set_id(1, 0, 0, 0, 0, 7, 0, 2'b01); cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 2'b00); half_a();
        chk("t4_fwd_sel", 128'(bus.fwd_sel), 128'(4'b0001));
        chk("t4_ex_opnd", 128'(bus.ex_opnd), {R1, DA}); half_b();
        idle(3);

        // load-use with flush: no stall, EX gets a bubble
        set_id(1, 1, 1, 0, 8, 0, 0, 2'b00); cycle();
        set_id(1, 0, 0, 0, 0, 8, 0, 2'b01); bus.flush = 1'b1; half_a();
        chk("t4_flush_stall", 128'(bus.stall), 128'(0)); half_b();
        set_id(0, 0, 0, 0, 0, 0, 0, 2'b00); half_a();
        chk("t4_flush_bubble", 128'(bus.fwd_sel), 128'(0)); half_b();
        idle(3);

        // halt with flush in the same cycle is not accepted
        set_id(1, 0, 0, 1, 0, 0, 0, 2'b00); bus.flush = 1'b1; cycle();
        set_id(0, 0, 0, 0, 0, 0, 0, 2'b00); half_a();
        chk("t5_flush_halt", 128'(bus.if_hold), 128'(0)); half_b();

        // halt accepted at t: if_hold from t+1, halt at t+4
        set_id(1, 0, 0, 1, 0, 0, 0, 2'b00); half_a();
        chk("t5_hold_t", 128'(bus.if_hold), 128'(0)); half_b();
        set_id(0, 0, 0, 0, 0, 0, 0, 2'b00);
        for (int n = 1; n <= 6; n++) begin
            half_a();
            chk("t5_halt_seq", 128'({bus.if_hold, bus.halt}), 128'({1'b1, n >= 4}));
            half_b();
        end
        do_reset();

        // reset pulse mid-drain returns to RUN
        set_id(1, 0, 0, 1, 0, 0, 0, 2'b00); cycle();
        idle(2);
        do_reset();
        idle(2);

`ifdef HAZARD_STATS_EN
        for (int p = 0; p < 3; p++) begin
            set_id(1, 1, 1, 0, 9, 0, 0, 2'b00); cycle();
            set_id(1, 0, 0, 0, 0, 9, 0, 2'b01); cycle(); cycle();
            idle(2);
        end
        #1 chk("stats_stall_cnt3", 128'(bus.stall_cnt), 128'(3));
`endif

        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            if (t_halt >= 0 && $urandom_range(0, 19) == 0) do_reset();
            else cycle();
        end

`ifdef HAZARD_STATS_EN
        #1;
        chk("stats_stall_cnt", 128'(bus.stall_cnt), 128'(m_stalls));
        chk("stats_fwd_cnt",   128'(bus.fwd_cnt),   128'(m_fwds));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
